// File: rtl/pair_triple_pkg.sv
// Shared types and constants for the pair/triple event counter.
package pair_triple_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL_HI = 2'd1,
        ACTIVE  = 2'd2,
        QUAL_LO = 2'd3
    } state_t;

    localparam logic [1:0] MODE_PC   = 2'd0;
    localparam logic [1:0] MODE_ACT  = 2'd1;
    localparam logic [1:0] MODE_CNT  = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd3;

    // Segments g..a, active-high; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to seven-segment pattern, purely combinational.
module seg7_hex_decoder (
    input  logic [3:0] value,
    output logic [6:0] seg
);
    import pair_triple_pkg::*;

    assign seg = SEG_TABLE[value];

endmodule

// File: rtl/pair_triple_event_counter.sv
// Debounced pair-or-more detector with saturating event counter and
// seven-segment display, wrapped in the TinyTapeout user pinout.
module pair_triple_event_counter #(
    parameter int MAX_COUNT = 10_000_000,
    parameter int N_IN      = 3,
    parameter int THRESH    = 2,
    parameter int STABLE    = 3,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    import pair_triple_pkg::*;

    localparam int PW  = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam int PCW = $clog2(N_IN + 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(MAX_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       STB      = 4'(STABLE);

    logic [N_IN-1:0]  sw_m, sw_s, sample;
    logic [2:0]       ctl_m, ctl_s;
    logic [PW-1:0]    pre;
    logic             tick;
    logic [PCW-1:0]   pc;
    logic             hi;
    state_t           state, state_n;
    logic [3:0]       run, run_n;
    logic             inc, engaged;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       mode;
    logic             clr;
    logic [3:0]       digit, shown;
    logic [6:0]       seg;
    logic             unused_bits;

    assign unused_bits = ^{ui_in, uio_in[7:3]};
    assign uio_oe      = 8'hF0;
    assign clr         = ctl_s[2];
    assign mode        = ctl_s[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_m  <= '0;
            sw_s  <= '0;
            ctl_m <= '0;
            ctl_s <= '0;
        end else begin
            sw_m  <= ui_in[N_IN-1:0];
            sw_s  <= sw_m;
            ctl_m <= uio_in[2:0];
            ctl_s <= ctl_m;
        end
    end

    assign tick = ena && (pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre    <= '0;
            sample <= '0;
        end else if (ena) begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) sample <= sw_s;
        end
    end

    always_comb begin
        pc = '0;
        for (int i = 0; i < N_IN; i++) pc = pc + PCW'(sample[i]);
    end

    assign hi = (int'(pc) >= THRESH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            run   <= '0;
        end else if (ena) begin
            state <= state_n;
            run   <= run_n;
        end
    end

    // run counts consecutive ticks that disagree with the settled level
    always_comb begin
        state_n = state;
        run_n   = run;
        if (tick) begin
            unique case (state)
                IDLE: if (hi) begin
                    if (STABLE == 1) state_n = ACTIVE;
                    else begin
                        state_n = QUAL_HI;
                        run_n   = 4'd1;
                    end
                end
                QUAL_HI: begin
                    if (!hi) begin
                        state_n = IDLE;
                        run_n   = '0;
                    end else if (run + 4'd1 >= STB) begin
                        state_n = ACTIVE;
                        run_n   = '0;
                    end else run_n = run + 4'd1;
                end
                ACTIVE: if (!hi) begin
                    if (STABLE == 1) state_n = IDLE;
                    else begin
                        state_n = QUAL_LO;
                        run_n   = 4'd1;
                    end
                end
                QUAL_LO: begin
                    if (hi) begin
                        state_n = ACTIVE;
                        run_n   = '0;
                    end else if (run + 4'd1 >= STB) begin
                        state_n = IDLE;
                        run_n   = '0;
                    end else run_n = run + 4'd1;
                end
                default: begin
                    state_n = IDLE;
                    run_n   = '0;
                end
            endcase
        end
    end

    always_comb begin
        inc     = (state_n == ACTIVE) && (state == IDLE || state == QUAL_HI);
        engaged = (state == ACTIVE) || (state == QUAL_LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (ena) begin
            if (clr) cnt <= '0;
            else if (inc && cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
    end

    // In hold mode the last shown digit simply stops updating
    always_comb begin
        unique case (mode)
            MODE_PC:  digit = 4'(pc);
            MODE_ACT: digit = {3'b000, engaged};
            MODE_CNT: digit = 4'(cnt);
            default:  digit = shown;
        endcase
    end

    seg7_hex_decoder u_dec (
        .value(digit),
        .seg  (seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown   <= '0;
            uo_out  <= 8'h3F;
            uio_out <= 8'h00;
        end else if (ena) begin
            shown   <= digit;
            uo_out  <= {hi, seg};
            uio_out <= {4'(cnt), 4'b0000};
        end
    end

endmodule

// File: tb/tb_pair_triple_event_counter.sv
// Randomised and directed bench against a run-length reference model.
module tb_pair_triple_event_counter;

    localparam int STABLE = 2;
    localparam int THRESH = 2;
    localparam int MAXC   = 4;

    localparam logic [6:0] SEGTAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests = 0;
    int fails = 0;

    pair_triple_event_counter #(
        .MAX_COUNT(MAXC),
        .N_IN     (3),
        .THRESH   (THRESH),
        .STABLE   (STABLE),
        .CNT_W    (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    // Reference: a settled level plus a count of disagreeing ticks
    logic [2:0] m_s1, m_s2, m_c1, m_c2, m_samp;
    int         m_pre, m_run, m_cnt, m_shown;
    bit         m_active;
    logic [7:0] m_uo, m_uio;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_c1 = '0; m_c2 = '0;
            m_samp = '0; m_pre = 0; m_run = 0; m_cnt = 0;
            m_shown = 0; m_active = 0;
            m_uo = 8'h3F; m_uio = 8'h00;
        end else begin
            int  pc, digit;
            bit  tk, hi, inc;
            pc  = $countones(m_samp);
            hi  = (pc >= THRESH);
            tk  = ena && (m_pre == MAXC - 1);
            inc = 0;
            if (ena) begin
                case (m_c2[1:0])
                    2'd0:    digit = pc;
                    2'd1:    digit = m_active ? 1 : 0;
                    2'd2:    digit = m_cnt;
                    default: digit = m_shown;
                endcase
                m_uo    = {hi, SEGTAB[digit]};
                m_uio   = 8'(m_cnt << 4);
                m_shown = digit;
                if (tk) begin
                    if (hi != m_active) begin
                        m_run++;
                        if (m_run == STABLE) begin
                            m_active = !m_active;
                            m_run    = 0;
                            inc      = m_active;
                        end
                    end else m_run = 0;
                end
                if (m_c2[2]) m_cnt = 0;
                else if (inc && m_cnt < 15) m_cnt++;
                if (tk) begin
                    m_samp = m_s2;
                    m_pre  = 0;
                end else m_pre++;
            end
            m_s2 = m_s1;
            m_s1 = ui_in[2:0];
            m_c2 = m_c1;
            m_c1 = uio_in[2:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("uo_out", 32'(uo_out), 32'(m_uo));
            chk("uio_out", 32'(uio_out), 32'(m_uio));
        end
    endtask

    task automatic do_reset(input logic [2:0] sw, input logic [2:0] ctl);
        @(negedge clk);
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = {5'b10101, sw};
        uio_in = {5'b11000, ctl};
        repeat (3) @(negedge clk);
        chk("reset_uo", 32'(uo_out), 32'h3F);
        chk("reset_uio", 32'(uio_out), 32'h00);
        chk("reset_oe", 32'(uio_oe), 32'hF0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = '0;
        uio_in = '0;

        do_reset(3'b000, 3'b000);
        cyc(8);
        chk("idle_uo", 32'(uo_out), 32'h3F);
        chk("idle_uio", 32'(uio_out), 32'h00);

        // First tick lands on the 4th edge, visible on the 5th
        do_reset(3'b111, 3'b000);
        cyc(4);
        chk("pre_tick_dp", 32'(uo_out[7]), 32'h0);
        cyc(1);
        chk("first_tick", 32'(uo_out), 32'hCF);

        do_reset(3'b011, 3'b010);
        cyc(16);
        chk("one_event_uo", 32'(uo_out), 32'h86);
        chk("one_event_cnt", 32'(uio_out), 32'h10);

        ui_in[2:0] = 3'b000;
        cyc(16);
        for (int i = 0; i < 6; i++) begin
            ui_in[2:0] = 3'b011;
            cyc(4);
            ui_in[2:0] = 3'b001;
            cyc(4);
        end
        chk("toggle_cnt", 32'(uio_out), 32'h10);

        ui_in[2:0] = 3'b111;
        cyc(16);
        ui_in[2:0] = 3'b001;
        cyc(4);
        ui_in[2:0] = 3'b111;
        cyc(16);
        chk("relapse_cnt", 32'(uio_out), 32'h20);
        uio_in[2:0] = 3'b001;
        cyc(4);
        chk("active_flag", 32'(uo_out), 32'h86);

        uio_in[2:0] = 3'b010;
        ui_in[2:0]  = 3'b000;
        cyc(16);
        for (int i = 0; i < 20; i++) begin
            ui_in[2:0] = 3'b111;
            cyc(12);
            ui_in[2:0] = 3'b000;
            cyc(12);
        end
        chk("saturate", 32'(uio_out), 32'hF0);

        uio_in[2:0] = 3'b110;
        ui_in[2:0]  = 3'b111;
        cyc(24);
        chk("clear_wins", 32'(uio_out), 32'h00);
        ui_in[2:0] = 3'b000;
        cyc(12);
        uio_in[2:0] = 3'b010;

        uio_in[2:0] = 3'b000;
        ui_in[2:0]  = 3'b111;
        cyc(16);
        chk("pc3_shown", 32'(uo_out), 32'hCF);
        uio_in[2:0] = 3'b011;
        cyc(4);
        ui_in[2:0] = 3'b001;
        cyc(16);
        chk("hold_digit", 32'(uo_out), 32'h4F);

        uio_in[2:0] = 3'b010;
        ui_in[2:0]  = 3'b000;
        cyc(16);
        chk("pre_freeze", 32'(uio_out), 32'h10);
        ui_in[2:0] = 3'b111;
        cyc(9);
        ena = 1'b0;
        cyc(40);
        chk("frozen_cnt", 32'(uio_out), 32'h10);
        ena = 1'b1;
        cyc(16);
        chk("resumed_cnt", 32'(uio_out), 32'h20);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) ui_in = 8'($urandom);
            if ($urandom_range(0, 5) == 0) uio_in[1:0] = 2'($urandom);
            uio_in[2]   = ($urandom_range(0, 15) == 0);
            uio_in[7:3] = 5'($urandom);
            ena = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                cyc(1);
                rst_n = 1'b1;
            end
            cyc($urandom_range(1, 12));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
